// File: rtl/strap_pkg.sv
// -----------------------------------------------------------------------------
// strap_pkg
//   Shared definitions for the strap sampler: FSM state encoding, default
//   parameter values and a helper that sizes the saturating-free counters.
// -----------------------------------------------------------------------------
package strap_pkg;

  // Sampler states: flush synchroniser, wait for stability, hold the word.
  typedef enum logic [1:0] {
    SYNC   = 2'd0,
    SETTLE = 2'd1,
    LOCKED = 2'd2
  } strap_state_e;

  localparam int unsigned DEF_WIDTH         = 8;
  localparam int unsigned DEF_SYNC_STAGES   = 2;
  localparam int unsigned DEF_STABLE_CYCLES = 4;
  localparam int unsigned DEF_TIMEOUT       = 64;

  // Bits needed to hold values 0..max_val, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/strap_sync.sv
// -----------------------------------------------------------------------------
// strap_sync
//   WIDTH-wide, SYNC_STAGES-deep flop chain bringing the asynchronous strap
//   levels into the ck domain. All stages reset to zero.
//
// Ports:
//   ck     in   clock, rising edge
//   nrst   in   asynchronous active-low reset
//   d      in   raw strap levels
//   q      out  fully synchronised straps (last stage)
//   q_pre  out  stage feeding the last stage (the value q takes next edge)
// -----------------------------------------------------------------------------
module strap_sync
  import strap_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             ck,
  input  logic             nrst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_pre
);

  logic [WIDTH-1:0] stage [SYNC_STAGES];

  always_ff @(posedge ck or negedge nrst) begin
    if (!nrst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= d;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q     = stage[SYNC_STAGES-1];
  assign q_pre = stage[SYNC_STAGES-2];

endmodule

// File: rtl/strap_sampler.sv
// -----------------------------------------------------------------------------
// strap_sampler
//   Samples a bus of static strap inputs after reset release. The bus is
//   synchronised, must read identically for STABLE_CYCLES consecutive edges
//   and is then latched as the configuration word. If the straps never settle
//   a lock is forced after TIMEOUT SETTLE edges. Once locked the straps are
//   still watched and any difference raises a sticky mismatch flag.
//
// Ports:
//   ck           in   clock, all state on rising edge
//   nrst         in   asynchronous active-low reset
//   strap_i      in   raw strap levels (asynchronous to ck)
//   resample_i   in   request a new sample, honoured only while LOCKED
//   cfg_o        out  latched configuration word (RESET_CFG before first lock)
//   cfg_valid_o  out  cfg_o holds a locked sample
//   busy_o       out  sampler in SYNC or SETTLE
//   mismatch_o   out  sticky: synced straps differ from cfg_o while LOCKED
//   timeout_o    out  sticky: last lock was forced by TIMEOUT
// -----------------------------------------------------------------------------
module strap_sampler
  import strap_pkg::*;
#(
  parameter int unsigned      WIDTH         = DEF_WIDTH,
  parameter int unsigned      SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int unsigned      STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned      TIMEOUT       = DEF_TIMEOUT,
  parameter logic [WIDTH-1:0] RESET_CFG     = '0
) (
  input  logic             ck,
  input  logic             nrst,
  input  logic [WIDTH-1:0] strap_i,
  input  logic             resample_i,
  output logic [WIDTH-1:0] cfg_o,
  output logic             cfg_valid_o,
  output logic             busy_o,
  output logic             mismatch_o,
  output logic             timeout_o
);

  localparam int unsigned SW = cnt_width(SYNC_STAGES);
  localparam int unsigned CW = cnt_width(STABLE_CYCLES);
  localparam int unsigned TW = cnt_width(TIMEOUT);

  localparam logic [SW-1:0] SYNC_LAST = SW'(SYNC_STAGES - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT - 1);

  strap_state_e     state;
  logic [SW-1:0]    sync_cnt;
  logic [CW-1:0]    cnt;
  logic [TW-1:0]    tcnt;
  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] sync_pre;

  logic settle_same;
  logic settle_lock;
  logic settle_force;

  strap_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .ck    (ck),
    .nrst  (nrst),
    .d     (strap_i),
    .q     (sync),
    .q_pre (sync_pre)
  );

  // Normal lock has priority over the forced lock on the same edge.
  always_comb begin
    settle_same  = (sync == shadow);
    settle_lock  = settle_same && (cnt == CNT_LAST);
    settle_force = !settle_lock && (tcnt == TCNT_LAST);
  end

  assign busy_o = (state != LOCKED);

  always_ff @(posedge ck or negedge nrst) begin
    if (!nrst) begin
      state       <= SYNC;
      sync_cnt    <= '0;
      cnt         <= '0;
      tcnt        <= '0;
      shadow      <= '0;
      cfg_o       <= RESET_CFG;
      cfg_valid_o <= 1'b0;
      mismatch_o  <= 1'b0;
      timeout_o   <= 1'b0;
    end else begin
      case (state)
        SYNC: begin
          if (sync_cnt == SYNC_LAST) begin
            // On this edge the last stage is still capturing the first real
            // sample, so the shadow is seeded from the stage feeding it; the
            // first SETTLE compare then sees a genuine strap value.
            state    <= SETTLE;
            shadow   <= sync_pre;
            sync_cnt <= '0;
            cnt      <= '0;
            tcnt     <= '0;
          end else begin
            sync_cnt <= sync_cnt + 1'b1;
          end
        end

        SETTLE: begin
          if (settle_lock) begin
            state       <= LOCKED;
            cfg_o       <= shadow;
            cfg_valid_o <= 1'b1;
            timeout_o   <= 1'b0;
            cnt         <= '0;
            tcnt        <= '0;
          end else if (settle_force) begin
            state       <= LOCKED;
            cfg_o       <= sync;
            cfg_valid_o <= 1'b1;
            timeout_o   <= 1'b1;
            cnt         <= '0;
            tcnt        <= '0;
          end else begin
            tcnt <= tcnt + 1'b1;
            if (settle_same) begin
              cnt <= cnt + 1'b1;
            end else begin
              shadow <= sync;
              cnt    <= '0;
            end
          end
        end

        LOCKED: begin
          if (resample_i) begin
            // cfg_o keeps the previous word until the next lock.
            state       <= SETTLE;
            cfg_valid_o <= 1'b0;
            mismatch_o  <= 1'b0;
            shadow      <= sync;
            cnt         <= '0;
            tcnt        <= '0;
          end else if (sync != cfg_o) begin
            mismatch_o <= 1'b1;
          end
        end

        default: begin
          state <= SYNC;
        end
      endcase
    end
  end

endmodule
